// File: rtl/dht11_scheduler_pkg.sv
// rtl/dht11_scheduler_pkg.sv - shared types and widths for the DHT11 measurement scheduler
package dht11_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRIG  = 2'd1,
    BUSY  = 2'd2,
    ABORT = 2'd3
  } state_t;

  localparam int MS_W    = 16;
  localparam int RETRY_W = 3;

endpackage

// File: rtl/dht11_scheduler_if.sv
// rtl/dht11_scheduler_if.sv - link between the scheduler (master) and the DHT11 single-wire controller (slave)
interface dht11_scheduler_if;

  logic       dht_start;
  logic       dht_rst;
  logic       dht_done;
  logic       dht_valid;
  logic [7:0] dht_rh;
  logic [7:0] dht_t;

  modport master (
    output dht_start, dht_rst,
    input  dht_done, dht_valid, dht_rh, dht_t
  );

  modport slave (
    input  dht_start, dht_rst,
    output dht_done, dht_valid, dht_rh, dht_t
  );

endinterface

// File: rtl/dht11_scheduler_tick_gen_1ms.sv
// rtl/dht11_scheduler_tick_gen_1ms.sv - one-cycle tick every CLK_HZ/1000 clocks
module tick_gen_1ms #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_tick
);

  localparam int TC    = CLK_HZ / 1000;
  localparam int CNT_W = (TC > 1) ? $clog2(TC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TC - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_tick;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= (r_cnt == CNT_LAST);
      r_cnt  <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/dht11_scheduler.sv
// rtl/dht11_scheduler.sv - DHT11 trigger scheduler: period/manual start, re-trigger gap, timeout abort, retry, result hold
// Optional read statistics counters are built when STATS_EN is defined.
module dht11_scheduler
  import dht11_sched_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int PERIOD_MS  = 2000,
  parameter int MIN_GAP_MS = 1000,
  parameter int TIMEOUT_MS = 50,
  parameter int MAX_RETRY  = 3,
  parameter int ABORT_CYC  = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_auto_en,
  input  logic                     i_req,
  dht11_scheduler_if.master        dht,
  output logic [7:0]               o_rh_out,
  output logic [7:0]               o_t_out,
  output logic                     o_data_valid,
  output logic                     o_new_data,
  output logic                     o_err,
  output logic                     o_busy,
  output logic [15:0]              o_ok_cnt,
  output logic [15:0]              o_fail_cnt
);

  localparam int ABT_W = $clog2(ABORT_CYC + 1);
  localparam logic [MS_W-1:0]    GAP_MAX    = MS_W'(MIN_GAP_MS);
  localparam logic [MS_W-1:0]    PER_LAST   = MS_W'(PERIOD_MS - 1);
  localparam logic [MS_W-1:0]    TO_MAX     = MS_W'(TIMEOUT_MS);
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY - 1);
  localparam logic [ABT_W-1:0]   ABT_LAST   = ABT_W'(ABORT_CYC - 1);

  state_t               r_state, w_next;
  logic                 w_tick;
  logic                 r_done_d;
  logic [MS_W-1:0]      r_gap, r_period, r_to;
  logic [ABT_W-1:0]     r_abt;
  logic [RETRY_W-1:0]   r_retry;
  logic                 r_pending, r_err, r_dv, r_nd;
  logic [7:0]           r_rh, r_t;
  logic                 w_cmpl, w_timeout, w_wrap, w_abort_end;
  logic                 w_start, w_rst, w_busy, w_ok, w_fail;

  tick_gen_1ms #(.CLK_HZ(CLK_HZ)) u_tick (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .o_tick  (w_tick)
  );

  // Completion is the falling edge of the controller's done level.
  assign w_cmpl      = r_done_d & ~dht.dht_done;
  assign w_timeout   = (r_to == TO_MAX);
  assign w_wrap      = i_auto_en & w_tick & (r_period == PER_LAST);
  assign w_abort_end = (r_abt == ABT_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_rst   = 1'b0;
    w_busy  = 1'b1;
    w_ok    = 1'b0;
    w_fail  = 1'b0;
    case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        if (r_pending && (r_gap == GAP_MAX)) w_next = TRIG;
      end
      TRIG: begin
        w_start = 1'b1;
        w_next  = BUSY;
      end
      BUSY: begin
        if (w_cmpl) begin
          w_ok   = dht.dht_valid;
          w_fail = ~dht.dht_valid;
          w_next = IDLE;
        end else if (w_timeout) begin
          w_next = ABORT;
        end
      end
      ABORT: begin
        w_rst = 1'b1;
        if (w_abort_end) begin
          w_fail = 1'b1;
          w_next = IDLE;
        end
      end
      default: begin
        w_busy = 1'b0;
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_done_d  <= 1'b0;
      r_gap     <= '0;
      r_period  <= '0;
      r_to      <= '0;
      r_abt     <= '0;
      r_pending <= 1'b0;
    end else begin
      r_done_d <= dht.dht_done;
      if (w_start)                          r_gap <= '0;
      else if (w_tick && (r_gap != GAP_MAX)) r_gap <= r_gap + 1'b1;
      if (!i_auto_en)  r_period <= '0;
      else if (w_tick) r_period <= w_wrap ? '0 : r_period + 1'b1;
      if (w_start)                                        r_to <= '0;
      else if ((r_state == BUSY) && w_tick && !w_timeout) r_to <= r_to + 1'b1;
      r_abt <= (r_state == ABORT) ? r_abt + 1'b1 : '0;
      // Set sources win over the TRIG clear so a request landing on the start cycle is not lost.
      if (i_req || w_wrap || (w_fail && (r_retry != RETRY_LAST))) r_pending <= 1'b1;
      else if (w_start)                                           r_pending <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_retry <= '0;
      r_err   <= 1'b0;
      r_dv    <= 1'b0;
      r_nd    <= 1'b0;
      r_rh    <= '0;
      r_t     <= '0;
    end else begin
      r_nd <= w_ok;
      if (w_ok) begin
        r_retry <= '0;
        r_err   <= 1'b0;
        r_dv    <= 1'b1;
        r_rh    <= dht.dht_rh;
        r_t     <= dht.dht_t;
      end else if (w_fail) begin
        if (r_retry == RETRY_LAST) begin
          r_retry <= '0;
          r_err   <= 1'b1;
        end else begin
          r_retry <= r_retry + 1'b1;
        end
      end
    end
  end

`ifdef STATS_EN
  logic [15:0] r_ok_cnt, r_fail_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ok_cnt   <= '0;
      r_fail_cnt <= '0;
    end else begin
      if (w_ok && (r_ok_cnt != 16'hFFFF))     r_ok_cnt   <= r_ok_cnt + 1'b1;
      if (w_fail && (r_fail_cnt != 16'hFFFF)) r_fail_cnt <= r_fail_cnt + 1'b1;
    end
  end

  assign o_ok_cnt   = r_ok_cnt;
  assign o_fail_cnt = r_fail_cnt;
`else
  assign o_ok_cnt   = '0;
  assign o_fail_cnt = '0;
`endif

  assign dht.dht_start = w_start;
  assign dht.dht_rst   = w_rst;
  assign o_rh_out      = r_rh;
  assign o_t_out       = r_t;
  assign o_data_valid  = r_dv;
  assign o_new_data    = r_nd;
  assign o_err         = r_err;
  assign o_busy        = w_busy;

endmodule

// File: tb/tb_dht11_scheduler.sv
// tb/tb_dht11_scheduler.sv - self-checking bench for dht11_scheduler (STATS_EN aware)
`timescale 1ns/1ps
module tb_dht11_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        auto_en = 1'b0;
  logic        req = 1'b0;
  logic [7:0]  rh_out, t_out;
  logic        data_valid, new_data, err, busy;
  logic [15:0] ok_cnt, fail_cnt;

  dht11_scheduler_if dif();

  dht11_scheduler #(
    .CLK_HZ(10_000), .PERIOD_MS(20), .MIN_GAP_MS(5),
    .TIMEOUT_MS(8), .MAX_RETRY(3), .ABORT_CYC(4)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_auto_en(auto_en), .i_req(req),
    .dht(dif),
    .o_rh_out(rh_out), .o_t_out(t_out), .o_data_valid(data_valid),
    .o_new_data(new_data), .o_err(err), .o_busy(busy),
    .o_ok_cnt(ok_cnt), .o_fail_cnt(fail_cnt)
  );

`ifdef STATS_EN
  localparam int EXP_OK = 1, EXP_FAIL = 3;
`else
  localparam int EXP_OK = 0, EXP_FAIL = 0;
`endif

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0, nd_cnt = 0, n_used = 0;
  int st_q[$];

  // Posedge-counting monitor, sampled just after each active edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (dif.dht_start) st_q.push_back(cyc);
    if (new_data) nd_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic pulse_req();
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic wait_start(input int bound, output int st);
    int k = 0;
    while (st_q.size() <= n_used && k < bound) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (st_q.size() <= n_used) begin
      failures++;
      $display("FAIL start_seen: no dht_start within %0d cycles", bound);
      st = cyc;
    end else begin
      st = st_q[n_used];
      n_used++;
    end
  endtask

  task automatic respond(input logic v, input logic [7:0] rh, input logic [7:0] t);
    repeat (5) @(negedge clk);
    dif.dht_done = 1'b1; dif.dht_valid = v; dif.dht_rh = rh; dif.dht_t = t;
    repeat (3) @(negedge clk);
    dif.dht_done = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  typedef struct {
    bit         use_req;
    bit         respond;
    bit         valid;
    logic [7:0] rh;
    logic [7:0] t;
    logic [7:0] exp_rh;
    logic [7:0] exp_t;
    bit         exp_err;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int rel, prev_st, st, st2, st3, nd0, k, c;
    vecs[0] = '{1'b1, 1'b1, 1'b1, 8'h2D, 8'h19, 8'h2D, 8'h19, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 8'hAA, 8'hBB, 8'h2D, 8'h19, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 8'hAA, 8'hBB, 8'h2D, 8'h19, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 8'hAA, 8'hBB, 8'h2D, 8'h19, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h2D, 8'h19, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 8'h30, 8'h1A, 8'h30, 8'h1A, 1'b0};
    dif.dht_done = 1'b0; dif.dht_valid = 1'b0; dif.dht_rh = 8'h00; dif.dht_t = 8'h00;

    repeat (3) @(negedge clk);
    chk("reset_outputs", {dif.dht_start, dif.dht_rst, rh_out, t_out, data_valid, new_data, err, busy}, 32'h0);
    chk("reset_counters", {ok_cnt, fail_cnt}, 32'h0);
    rst_n = 1'b1;
    rel = cyc;
    prev_st = 0;

    for (int i = 0; i < 6; i++) begin
      nd0 = nd_cnt;
      if (vecs[i].use_req) pulse_req();
      wait_start(400, st);
      if (i == 0) chk_rng("first_start_delay", st - rel, 48, 56);
      else        chk_rng($sformatf("v%0d_start_gap", i), st - prev_st, 41, 1000);
      prev_st = st;
      if (vecs[i].respond) begin
        respond(vecs[i].valid, vecs[i].rh, vecs[i].t);
        chk($sformatf("v%0d_rh", i), rh_out, vecs[i].exp_rh);
        chk($sformatf("v%0d_t", i), t_out, vecs[i].exp_t);
        chk($sformatf("v%0d_new_data", i), nd_cnt - nd0, vecs[i].valid ? 1 : 0);
        chk($sformatf("v%0d_busy", i), busy, 1'b0);
      end else begin
        k = 0;
        while (!dif.dht_rst && k < 150) begin @(negedge clk); k++; end
        chk_rng("abort_delay", cyc - st, 72, 83);
        k = 0;
        while (dif.dht_rst && k < 10) begin @(negedge clk); k++; end
        chk("abort_len", k, 4);
      end
      chk($sformatf("v%0d_err", i), err, vecs[i].exp_err);
      chk($sformatf("v%0d_data_valid", i), data_valid, 1'b1);
      if (i == 3) begin
        chk("ok_cnt", ok_cnt, EXP_OK);
        chk("fail_cnt", fail_cnt, EXP_FAIL);
        repeat (100) @(negedge clk);
        chk("no_start_after_err", st_q.size(), n_used);
      end
    end

    // Idle with the gap satisfied: start follows req by two cycles.
    repeat (60) @(negedge clk);
    c = cyc;
    pulse_req();
    wait_start(50, st);
    chk("req_latency", st - c, 2);
    respond(1'b1, 8'h22, 8'h11);
    chk("lat_rh", {rh_out, t_out}, 16'h2211);

    // Periodic mode, then a req coinciding with the period wrap.
    auto_en = 1'b1;
    wait_start(300, st);
    respond(1'b1, 8'h40, 8'h20);
    wait_start(300, st2);
    chk("auto_period", st2 - st, 200);
    respond(1'b1, 8'h41, 8'h21);
    while (cyc < st2 + 198) @(negedge clk);
    pulse_req();
    wait_start(300, st3);
    chk("coincident_start", st3 - st2, 200);
    respond(1'b1, 8'h42, 8'h22);
    while (cyc < st3 + 150) @(negedge clk);
    chk("coincident_single", st_q.size(), n_used);
    auto_en = 1'b0;

    // req during BUSY is served once after completion plus gap.
    pulse_req();
    wait_start(200, st);
    repeat (2) @(negedge clk);
    chk("busy_flag", busy, 1'b1);
    pulse_req();
    respond(1'b1, 8'h55, 8'h66);
    wait_start(200, st2);
    chk_rng("busy_req_gap", st2 - st, 41, 120);
    respond(1'b1, 8'h57, 8'h68);
    repeat (150) @(negedge clk);
    chk("busy_req_single", st_q.size(), n_used);

    // Asynchronous reset mid-BUSY clears every output at once.
    pulse_req();
    wait_start(200, st);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midbusy_reset_outputs", {dif.dht_start, dif.dht_rst, rh_out, t_out, data_valid, new_data, err, busy}, 32'h0);
    chk("midbusy_reset_counters", {ok_cnt, fail_cnt}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
